// File: rtl/dmem_byte_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_byte_ctrl
//  Purpose  : MEM-stage data-memory responder. Services LW/LB/SW/SB against
//             an internal single-port synchronous-read word SRAM. Loads and
//             byte-store read-modify-writes take two cycles and stall the
//             pipeline for one cycle; word stores complete in one cycle.
//  Options  : DMEM_ALIGN_CHECK_EN - flag and suppress misaligned LW/SW.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_byte_ctrl #(
   parameter int AW      = 8,
   parameter int SIGN_LB = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memread,
   input  logic        memwrite,
   input  logic        loadbyte,
   input  logic        savebyte,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        stall,
   output logic        misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_RMW  = 2'd2
   } state_t;

   state_t      r_state;
   logic [31:0] r_mem [0:(2**AW)-1];
   logic [31:0] r_q;
   logic [31:0] r_rdata_hold;

   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic          w_is_sw;
   logic          w_is_sb;
   logic          w_is_load;
   logic          w_sw_fault;
   logic          w_lw_fault;
   logic [7:0]    w_byte;
   logic [31:0]   w_load_val;
   logic [31:0]   w_merged;
   logic          w_mem_we;
   logic          w_mem_re;
   logic [31:0]   w_mem_wdata;
   logic          w_unused_addr;

   // Address decode: upper address bits fall away so accesses wrap.
   assign w_idx         = addr[AW+1:2];
   assign w_lane        = addr[1:0];
   assign w_unused_addr = ^addr[31:AW+2];

   // Request classification: a store always takes priority over a load.
   assign w_is_sw   = memwrite & ~savebyte;
   assign w_is_sb   = memwrite &  savebyte;
   assign w_is_load = memread  & ~memwrite;

`ifdef DMEM_ALIGN_CHECK_EN
   assign w_sw_fault = (r_state == S_IDLE) & w_is_sw & (w_lane != 2'd0);
   assign w_lw_fault = (r_state == S_RD) & ~loadbyte & (w_lane != 2'd0);
`else
   assign w_sw_fault = 1'b0;
   assign w_lw_fault = 1'b0;
`endif

   assign misalign = w_sw_fault | w_lw_fault;

   // Load result: lane select with optional sign extension, or full word.
   always_comb begin
      w_byte = r_q[{w_lane, 3'b000} +: 8];
      if (w_lw_fault)
         w_load_val = 32'd0;
      else if (loadbyte)
         w_load_val = (SIGN_LB != 0) ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};
      else
         w_load_val = r_q;
   end

   // Byte-store merge of the new byte into the word read in the first cycle.
   always_comb begin
      w_merged = r_q;
      w_merged[{w_lane, 3'b000} +: 8] = wdata[7:0];
   end

   assign rdata = (r_state == S_RD) ? w_load_val : r_rdata_hold;
   assign stall = (r_state == S_IDLE) & (w_is_sb | w_is_load);

   // SRAM port control; a reset in RMW drops the pending merged write.
   assign w_mem_re    = (r_state == S_IDLE) & (w_is_sb | w_is_load);
   assign w_mem_we    = ~reset & (((r_state == S_IDLE) & w_is_sw & ~w_sw_fault)
                                  | (r_state == S_RMW));
   assign w_mem_wdata = (r_state == S_RMW) ? w_merged : wdata;

   // Single-port SRAM with synchronous read; contents survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_we)
         r_mem[w_idx] <= w_mem_wdata;
      if (w_mem_re)
         r_q <= r_mem[w_idx];
   end

   // Access sequencer and load-result hold register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_rdata_hold <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_is_sb)
                  r_state <= S_RMW;
               else if (w_is_load)
                  r_state <= S_RD;
            end
            S_RD: begin
               if (!w_lw_fault)
                  r_rdata_hold <= w_load_val;
               r_state <= S_IDLE;
            end
            S_RMW:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
